reg_write_arbiter: RTL and testbench
====================================

// Module: reg_write_arbiter
// PURPOSE
//  Round-robin arbiter sharing the write port of one 32-bit enable-gated Register among N_REQ requesters.
//  Samples per-requester req/data, picks one winner per cycle, drives the Register's d/en and returns a one-cycle grant pulse.
//  Sits between the processor's write sources (ALU, load unit, CSR/debug) and the shared state register.
// PARAMETERS
//  N_REQ   4   number of requesters, 2..8
//  DW      32  data width; matches the Register d/q width
//  SRC_W   derived $clog2(N_REQ); width of wr_src
// PORTS
//  clk       in   1            rising-edge clock, sole clock of the block
//  reset     in   1            synchronous, active-high reset
//  req       in   N_REQ        request per requester; held until its gnt pulse
//  data      in   N_REQ*DW     requester i payload in data[i*DW +: DW]; stable while req[i]=1
//  stall     in   1            downstream hold; no grants issued while 1
//  gnt       out  N_REQ        one-hot, one-cycle grant pulse
//  wr_en     out  1            to Register en
//  wr_data   out  DW           to Register d
//  wr_src    out  SRC_W        index of requester being written
//  busy      out  1            1 when any req pending and not granted this cycle
// BEHAVIOUR
//  Sync reset: gnt=0, wr_en=0, wr_data=0, wr_src=0, ptr=0, state=IDLE; busy is combinational (0 during reset).
//  All outputs except busy are registered. Latency: req sampled at edge k -> gnt/wr_en/wr_data valid cycle k+1.
//  Register q updates at edge k+1 (its en=wr_en); total req-to-q latency 2 edges.
//  Eligible set E = req & ~gnt (requester granted this cycle cannot win the next edge: no back-to-back grants).
//  Winner = first set bit of E searching ptr, ptr+1, ... wrapping N_REQ-1 -> 0.
//  On grant to i: gnt[i]=1, wr_en=1, wr_data=data[i], wr_src=i, ptr <= (i+1) mod N_REQ.
//  No winner or stall=1: gnt=0, wr_en=0, wr_data holds previous value, ptr unchanged.
//  Requester protocol: keep req[i] and data[i] stable until gnt[i]=1; may drop req[i] in the gnt cycle.
//  req[i] dropped before grant: request withdrawn, nothing written. Reasserting after gnt = new request.
//  FSM: IDLE (no grant issued) / GRANT (grant pulse this cycle).
//   IDLE->GRANT: E!=0 and stall=0.  GRANT->GRANT: E!=0 and stall=0.  GRANT->IDLE: E==0 or stall=1.
//  stall rising while in GRANT: the current pulse completes (already registered); next edge goes IDLE.
//  Reset mid-grant: the pulse is killed at the next edge, no write occurs after reset edge, ptr returns to 0.
//  busy = |(req & ~gnt) ; flags a starving or stalled requester to the pipeline hazard logic.
//  wr_src/wr_data ignore X on non-winning data lanes.
// CONFIGURATION
//  REG_ARB_LOCK_EN defined: extra input lock [N_REQ]. If gnt[i]=1 and lock[i]=1 at an edge, requester i
//   keeps priority: E includes i, winner forced to i if req[i]=1, ptr not advanced. Enables back-to-back
//   writes (burst). Lock ignored when stall=1 (stall still wins). Lock released when lock[i]=0 or req[i]=0.
//  REG_ARB_LOCK_EN undefined: no lock port; strict round-robin, no requester granted two consecutive cycles.
// TESTING
//  1) reset=1 two cycles with req=4'hF -> gnt=0, wr_en=0, wr_data=0, ptr=0; Register q stays 0.
//  2) req=4'b0100, data[2]=32'hDEADBEEF at edge 1 -> cycle 2: gnt=4'b0100, wr_en=1, wr_src=2; q=DEADBEEF after edge 2.
//  3) req=4'hF held, each dropped on its gnt -> grants 0,1,2,3 in consecutive cycles, then gnt=0.
//  4) req=4'hF held permanently -> gnt sequence 1,2,4,8,1,... no repeat before all four served.
//  5) req=4'b0011, stall=1 for 3 cycles then 0 -> gnt=0/wr_en=0/busy=1 while stalled; grant to 0 one cycle after release.
//  6) Grant to 1 in flight, reset=1 -> next edge gnt=0, wr_en=0, ptr=0; (LOCK_EN build) lock[3]=1, req[3]=1 -> 3 consecutive gnt[3] with req[0]=1 pending.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one enable-gated register write port among N_REQ requesters.
// Optional burst lock (back-to-back grants to one requester) enabled by defining REG_ARB_LOCK_EN.
module reg_write_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DW    = 32,
  parameter int unsigned SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DW-1:0]     data,
  input  logic                    stall,
`ifdef REG_ARB_LOCK_EN
  input  logic [N_REQ-1:0]        lock,
`endif
  output logic [N_REQ-1:0]        gnt,
  output logic                    wr_en,
  output logic [DW-1:0]           wr_data,
  output logic [SRC_W-1:0]        wr_src,
  output logic                    busy
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic               wr_en_q, wr_en_d;
  logic [DW-1:0]      wr_data_q, wr_data_d;
  logic [SRC_W-1:0]   wr_src_q, wr_src_d;
  logic [SRC_W-1:0]   ptr_q, ptr_d;

  logic [N_REQ-1:0]   gnt_live;
  logic [N_REQ-1:0]   elig;
  logic               win_found;
  logic [SRC_W-1:0]   win_idx;
  logic               lock_hit;
  int unsigned        idx;

  // gnt_q is only meaningful while a pulse is out; gating by state keeps that explicit.
  assign gnt_live = (state_q == StGrant) ? gnt_q : '0;

  always_comb begin
    elig      = req & ~gnt_live;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    lock_hit  = 1'b0;

    for (int k = 0; k < int'(N_REQ); k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!win_found && elig[idx]) begin
        win_found = 1'b1;
        win_idx   = SRC_W'(idx);
      end
    end

`ifdef REG_ARB_LOCK_EN
    // A locked current winner keeps the port; wr_src_q names it since gnt is one-hot.
    lock_hit = |(gnt_live & lock & req);
    if (lock_hit) begin
      win_found = 1'b1;
      win_idx   = wr_src_q;
    end
`endif

    state_d   = StIdle;
    gnt_d     = '0;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    wr_src_d  = wr_src_q;
    ptr_d     = ptr_q;

    if (win_found && !stall) begin
      state_d          = StGrant;
      gnt_d[win_idx]   = 1'b1;
      wr_en_d          = 1'b1;
      wr_data_d        = data[int'(win_idx)*DW +: DW];
      wr_src_d         = win_idx;
      if (!lock_hit) begin
        ptr_d = (int'(win_idx) == int'(N_REQ) - 1) ? '0 : win_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      gnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      wr_src_q  <= '0;
      ptr_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      wr_src_q  <= wr_src_d;
      ptr_q     <= ptr_d;
    end
  end

  assign gnt     = gnt_q;
  assign wr_en   = wr_en_q;
  assign wr_data = wr_data_q;
  assign wr_src  = wr_src_q;
  assign busy    = !reset && |(req & ~gnt_live);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with a behavioural model of the downstream register.
module tb_reg_write_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req;
  logic [127:0] data;
  logic         stall;
  logic [3:0]   gnt;
  logic         wr_en;
  logic [31:0]  wr_data;
  logic [1:0]   wr_src;
  logic         busy;
  logic [31:0]  q;
`ifdef REG_ARB_LOCK_EN
  logic [3:0]   lock;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_write_arbiter #(.N_REQ(4), .DW(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .data    (data),
    .stall   (stall),
`ifdef REG_ARB_LOCK_EN
    .lock    (lock),
`endif
    .gnt     (gnt),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .wr_src  (wr_src),
    .busy    (busy)
  );

  // Shared register fed by the arbiter.
  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else if (wr_en) q <= wr_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    step();
    reset = 1'b0;
  endtask

  function automatic logic [31:0] lane(input int i);
    return 32'h1111_1111 * (i + 1);
  endfunction

  initial begin
    logic [3:0] seq4 [5];
    seq4 = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    reset = 1'b1;
    req   = 4'hF;
    stall = 1'b0;
`ifdef REG_ARB_LOCK_EN
    lock  = '0;
`endif
    for (int i = 0; i < 4; i++) data[i*32 +: 32] = lane(i);

    // Reset held with all requests up
    step();
    step();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_wr_en", 32'(wr_en), 32'h0);
    chk("rst_wr_data", wr_data, 32'h0);
    chk("rst_wr_src", 32'(wr_src), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_q", q, 32'h0);

    // Single requester 2
    reset = 1'b0;
    req   = 4'b0100;
    data[64 +: 32] = 32'hDEAD_BEEF;
    step();
    chk("single_gnt", 32'(gnt), 32'h4);
    chk("single_wr_en", 32'(wr_en), 32'h1);
    chk("single_wr_src", 32'(wr_src), 32'h2);
    chk("single_wr_data", wr_data, 32'hDEAD_BEEF);
    req = 4'b0000;
    step();
    chk("single_q", q, 32'hDEAD_BEEF);
    chk("single_gnt_off", 32'(gnt), 32'h0);
    chk("single_hold_data", wr_data, 32'hDEAD_BEEF);
    data[64 +: 32] = lane(2);

    // All request, each drops on its grant
    do_reset();
    req = 4'hF;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_drop_gnt", 32'(gnt), 32'(1) << i);
      chk("rr_drop_data", wr_data, lane(i));
      req[i] = 1'b0;
    end
    step();
    chk("rr_drop_end_gnt", 32'(gnt), 32'h0);
    chk("rr_drop_end_en", 32'(wr_en), 32'h0);

    // All request held permanently
    req = 4'hF;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr_hold_gnt", 32'(gnt), 32'(seq4[i]));
    end
    req = 4'h0;
    step();

    // Stall
    do_reset();
    req   = 4'b0011;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_gnt", 32'(gnt), 32'h0);
      chk("stall_en", 32'(wr_en), 32'h0);
      chk("stall_busy", 32'(busy), 32'h1);
    end
    stall = 1'b0;
    step();
    chk("unstall_gnt", 32'(gnt), 32'h1);
    chk("unstall_src", 32'(wr_src), 32'h0);
    chk("unstall_busy", 32'(busy), 32'h1);
    req = 4'b0010;
    step();
    chk("unstall_gnt1", 32'(gnt), 32'h2);
    req = 4'b0000;
    step();
    chk("unstall_idle", 32'(gnt), 32'h0);
    chk("unstall_busy0", 32'(busy), 32'h0);

    // Stall rising while a grant is out; ptr now 2 so requester 0 wins first
    req = 4'b0011;
    step();
    chk("stallrise_gnt0", 32'(gnt), 32'h1);
    req   = 4'b0010;
    stall = 1'b1;
    step();
    chk("stallrise_idle", 32'(gnt), 32'h0);
    stall = 1'b0;
    step();
    chk("stallrise_gnt1", 32'(gnt), 32'h2);
    req = 4'b0000;
    step();

    // Reset with a grant to requester 1 in flight (ptr is 2 here)
    req = 4'b0010;
    step();
    chk("midrst_pre_gnt", 32'(gnt), 32'h2);
    reset = 1'b1;
    step();
    chk("midrst_gnt", 32'(gnt), 32'h0);
    chk("midrst_en", 32'(wr_en), 32'h0);
    chk("midrst_data", wr_data, 32'h0);
    reset = 1'b0;
    req   = 4'b0011;
    step();
    chk("midrst_ptr0", 32'(gnt), 32'h1);
    req = 4'b0000;
    step();

`ifdef REG_ARB_LOCK_EN
    // Burst lock on requester 3 with requester 0 pending
    do_reset();
    req  = 4'b1000;
    lock = 4'b1000;
    step();
    chk("lock_gnt_a", 32'(gnt), 32'h8);
    req = 4'b1001;
    step();
    chk("lock_gnt_b", 32'(gnt), 32'h8);
    step();
    chk("lock_gnt_c", 32'(gnt), 32'h8);
    lock = 4'b0000;
    step();
    chk("lock_release", 32'(gnt), 32'h1);
    req = 4'b0000;
    step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
